srff_excite_driver: RTL and testbench

//  Inverse side of an SR flip-flop. Takes a requested target state and derives s/r from the excitation table.

---
 rtl/srff_pkg.sv | 32 +++
 rtl/srff_excite.sv | 15 +
 rtl/srff_excite_driver.sv | 145 ++++++++++++++
 tb/tb_srff_excite_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/srff_pkg.sv
// Shared types and constants for the SR-flop excitation driver.
// Build option: define SRFF_COMPLEMENT_CHECK_EN to treat q_fb==qb_fb as a fault.
package srff_pkg;

    // Driver FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DRIVE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Excitation codes, packed as {s, r}
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_RST  = 2'b01;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF          = 3;

    // Inverse SR table: which {s, r} moves the flop from cur to tgt.
    // The don't-care input of each transition is tied low so s&&r never occurs.
    function automatic logic [1:0] sr_excite(input logic cur, input logic tgt);
        logic [1:0] sr;
        sr = SR_HOLD;
        if (cur != tgt) begin
            sr = tgt ? SR_SET : SR_RST;
        end
        return sr;
    endfunction

endpackage

// File: rtl/srff_excite.sv
// Combinational excitation lookup: current/target flop state to {s, r}.
module srff_excite
    import srff_pkg::*;
(
    input  logic       cur,
    input  logic       tgt,
    output logic [1:0] sr_c
);

    // Hold when already at target, otherwise set or reset toward it
    always_comb begin
        sr_c = sr_excite(cur, tgt);
    end

endmodule

// File: rtl/srff_excite_driver.sv
// Request-driven SR flop excitation driver with feedback check and timeout.
// Build option: SRFF_COMPLEMENT_CHECK_EN adds a q_fb==qb_fb fault check in CHECK/WAIT.
module srff_excite_driver
    import srff_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_q,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    input  logic qb_fb,
    output logic done,
    output logic err
);

    state_t             state_q;
    state_t             state_d;
    logic               acc_q;
    logic               acc_d;
    logic               tgt_q;
    logic               tgt_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               s_d;
    logic               r_d;
    logic               done_d;
    logic               err_d;
    logic               ready_d;
    logic [1:0]         sr_c;
    logic               fault_c;

    srff_excite u_excite (
        .cur  (q_fb),
        .tgt  (tgt_q),
        .sr_c (sr_c)
    );

`ifdef SRFF_COMPLEMENT_CHECK_EN
    // Equal q/qb means the flop or its wiring is broken
    always_comb begin
        fault_c = (q_fb == qb_fb);
    end
`else
    logic unused_qb_fb;

    // Complement feedback is not monitored in this build
    always_comb begin
        fault_c      = 1'b0;
        unused_qb_fb = qb_fb;
    end
`endif

    // State, capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            tgt_q     <= 1'b0;
            cnt_q     <= '0;
            s         <= 1'b0;
            r         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            s         <= s_d;
            r         <= r_d;
            done      <= done_d;
            err       <= err_d;
            req_ready <= ready_d;
        end
    end

    // Next state and next registered outputs; s/r only leave hold while in DRIVE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // A captured request is evaluated one cycle after acceptance
                if (acc_q) begin
                    acc_d   = 1'b0;
                    state_d = CHECK;
                end else if (req_valid && req_ready) begin
                    acc_d = 1'b1;
                    tgt_d = req_q;
                end
            end
            CHECK: begin
                if (fault_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sr_c == SR_HOLD) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    s_d     = sr_c[1];
                    r_d     = sr_c[0];
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fault_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) && !acc_d;
    end

endmodule

// File: tb/tb_srff_excite_driver.sv
// Directed bench: driver paired with a behavioural positive-edge SR flop.
module tb_srff_excite_driver;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic req_valid = 1'b0;
    logic req_q     = 1'b0;
    logic req_ready;
    logic s;
    logic r;
    logic done;
    logic err;
    logic q_fb;
    logic qb_fb;

    logic fq;
    logic stuck0   = 1'b0;
    logic qb_force = 1'b0;

    int tests = 0;
    int fails = 0;

    srff_excite_driver #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_q     (req_q),
        .req_ready (req_ready),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .qb_fb     (qb_fb),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural SR flop, reset to 0
    always @(posedge clk or posedge rst) begin
        if (rst)            fq <= 1'b0;
        else if (s && !r)   fq <= 1'b1;
        else if (r && !s)   fq <= 1'b0;
    end

    assign q_fb  = stuck0 ? 1'b0 : fq;
    assign qb_fb = qb_force ? 1'b1 : ~q_fb;

    // Illegal SR input must never reach the flop
    always @(negedge clk) begin
        tests++;
        assert (!(s && r)) else begin
            fails++;
            $error("FAIL sr_illegal observed s=%0b r=%0b expected not both 1", s, r);
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset and release
        #12;
        chk("rst_s", s, 1'b0);
        chk("rst_r", r, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", req_ready, 1'b0);
        step();
        rst = 1'b0;
        chk("rel_ready_before_edge", req_ready, 1'b0);
        step();
        chk("rel_ready_after_edge", req_ready, 1'b1);
        chk("rel_done", done, 1'b0);
        chk("rel_err", err, 1'b0);
        step();
        chk("rel_s", s, 1'b0);
        chk("rel_r", r, 1'b0);

        // 2: set from q=0, done four edges after accept
        req_valid = 1'b1;
        req_q     = 1'b1;
        step();                               // E0
        req_valid = 1'b0;
        chk("set_ready_drop", req_ready, 1'b0);
        chk("set_e0_s", s, 1'b0);
        step();                               // E1
        chk("set_e1_s", s, 1'b0);
        chk("set_e1_done", done, 1'b0);
        step();                               // E2
        chk("set_e2_s", s, 1'b1);
        chk("set_e2_r", r, 1'b0);
        chk("set_e2_q", q_fb, 1'b0);
        step();                               // E3
        chk("set_e3_s", s, 1'b0);
        chk("set_e3_q", q_fb, 1'b1);
        chk("set_e3_done", done, 1'b0);
        step();                               // E4
        chk("set_e4_done", done, 1'b1);
        chk("set_e4_err", err, 1'b0);
        chk("set_e4_ready", req_ready, 1'b1);
        step();
        chk("set_done_pulse_end", done, 1'b0);

        // 3: target already reached, done two edges after accept
        req_valid = 1'b1;
        req_q     = 1'b1;
        step();                               // E0
        req_valid = 1'b0;
        step();                               // E1
        chk("hold_e1_s", s, 1'b0);
        chk("hold_e1_r", r, 1'b0);
        chk("hold_e1_done", done, 1'b0);
        step();                               // E2
        chk("hold_e2_done", done, 1'b1);
        chk("hold_e2_s", s, 1'b0);
        chk("hold_e2_r", r, 1'b0);
        step();
        chk("hold_done_pulse_end", done, 1'b0);

        // 4: flop stuck at 0, timeout after four WAIT samples
        stuck0    = 1'b1;
        req_valid = 1'b1;
        req_q     = 1'b1;
        step();                               // E0
        req_valid = 1'b0;
        step();                               // E1
        step();                               // E2
        chk("to_e2_s", s, 1'b1);
        step();                               // E3
        chk("to_e3_s", s, 1'b0);
        for (int i = 4; i <= 6; i++) begin
            step();                           // E4..E6
            chk("to_wait_err", err, 1'b0);
            chk("to_wait_done", done, 1'b0);
            chk("to_wait_s", s, 1'b0);
        end
        step();                               // E7
        chk("to_e7_err", err, 1'b1);
        chk("to_e7_done", done, 1'b0);
        chk("to_e7_ready", req_ready, 1'b1);
        step();
        chk("to_err_pulse_end", err, 1'b0);
        chk("to_no_done", done, 1'b0);
        stuck0 = 1'b0;

        // 5: reset asserted during DRIVE
        req_valid = 1'b1;
        req_q     = 1'b0;
        step();                               // E0
        req_valid = 1'b0;
        step();                               // E1
        step();                               // E2
        chk("rd_drive_r", r, 1'b1);
        chk("rd_drive_s", s, 1'b0);
        rst = 1'b1;
        #1;
        chk("rd_async_r", r, 1'b0);
        chk("rd_async_s", s, 1'b0);
        chk("rd_async_ready", req_ready, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("rd_ready_back", req_ready, 1'b1);
        chk("rd_no_done", done, 1'b0);
        chk("rd_no_err", err, 1'b0);
        step();
        chk("rd_no_done2", done, 1'b0);
        chk("rd_no_err2", err, 1'b0);
        chk("rd_no_r", r, 1'b0);

        // 6: q_fb == qb_fb during WAIT
        req_valid = 1'b1;
        req_q     = 1'b1;
        step();                               // E0
        req_valid = 1'b0;
        step();                               // E1
        step();                               // E2
        chk("cc_e2_s", s, 1'b1);
        step();                               // E3
        qb_force = 1'b1;
        step();                               // E4
`ifdef SRFF_COMPLEMENT_CHECK_EN
        chk("cc_err", err, 1'b1);
        chk("cc_done", done, 1'b0);
`else
        chk("cc_err", err, 1'b0);
        chk("cc_done", done, 1'b1);
`endif
        qb_force = 1'b0;
        step();
        chk("cc_err_end", err, 1'b0);
        chk("cc_done_end", done, 1'b0);

        // 7: valid held through a transaction, next accept when ready returns
        req_valid = 1'b1;
        req_q     = 1'b0;
        step();                               // E0
        step();                               // E1
        chk("b2b_busy_ready", req_ready, 1'b0);
        step();                               // E2
        chk("b2b_e2_r", r, 1'b1);
        step();                               // E3
        step();                               // E4
        chk("b2b_e4_done", done, 1'b1);
        chk("b2b_e4_ready", req_ready, 1'b1);
        step();                               // second accept
        req_valid = 1'b0;
        chk("b2b_acc_ready", req_ready, 1'b0);
        chk("b2b_acc_done", done, 1'b0);
        step();
        chk("b2b_chk_done", done, 1'b0);
        step();
        chk("b2b_hold_done", done, 1'b1);
        chk("b2b_hold_r", r, 1'b0);
        step();
        chk("b2b_end_ready", req_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
